// File: rtl/aes_pkg.sv
// Shared AES tables, FSM state type and byte-level transforms for the inverse cipher.
// Latency: pure combinational helpers, no state.
// Backpressure: not applicable.
package aes_pkg;

    typedef enum logic [2:0] {IDLE, KEXP, ARK, ROUND, DONE} state_t;

    // Byte 0 of a block sits at index 0, which is the most significant byte [127:120].
    typedef logic [0:15][7:0] bytes_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

    // Round constant for index 1..10; anything else yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1: return 8'h01;   4'd2: return 8'h02;   4'd3: return 8'h04;
            4'd4: return 8'h08;   4'd5: return 8'h10;   4'd6: return 8'h20;
            4'd7: return 8'h40;   4'd8: return 8'h80;   4'd9: return 8'h1b;
            4'd10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Row r of the column-major state is rotated right by r positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        bytes_t a, o;
        a = s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4*c+r] = a[4*((c-r+4)%4)+r];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        bytes_t a, o;
        a = s;
        for (int i = 0; i < 16; i++)
            o[i] = INV_SBOX[a[i]];
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        bytes_t a, o;
        logic [7:0] x1, x2, x4, x8;
        logic [7:0] m9 [4], mb [4], md [4], me [4];
        a = s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                x1 = a[4*c+r];
                x2 = xt(x1);
                x4 = xt(x2);
                x8 = xt(x4);
                m9[r] = x8 ^ x1;
                mb[r] = x8 ^ x2 ^ x1;
                md[r] = x8 ^ x4 ^ x1;
                me[r] = x8 ^ x4 ^ x2;
            end
            o[4*c+0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[4*c+1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[4*c+2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[4*c+3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One AES-128 key-schedule step, forward (K_i -> K_i+1) or inverse (K_i+1 -> K_i).
// Latency: combinational.
// Backpressure: none; caller registers the result.
module aes128_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    input  logic         dir,
    output logic [127:0] rk_out
);

    logic [31:0] w0, w1, w2, w3, t_in, t;
    logic [31:0] f0, f1, f2, f3, i0, i1, i2, i3;

    assign {w0, w1, w2, w3} = rk_in;

    // The inverse step recovers w3 of the previous key first, so a single
    // SubWord serves both directions depending on which word feeds it.
    assign t_in = dir ? (w3 ^ w2) : w3;
    assign t    = sub_word(rot_word(t_in)) ^ {rcon, 24'h0};

    assign f0 = w0 ^ t;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign i3 = w3 ^ w2;
    assign i2 = w2 ^ w1;
    assign i1 = w1 ^ w0;
    assign i0 = w0 ^ t;

    assign rk_out = dir ? {i0, i1, i2, i3} : {f0, f1, f2, f3};

endmodule

// File: rtl/aes128_iter_decrypt.sv
// Iterative AES-128 decrypt, one inverse round per cycle, round keys derived on the fly.
// Latency: 12 cycles accept-to-out_valid with cached key, 22 with a fresh key expansion.
// Backpressure: single block in flight; in_ready low until the result is taken via out_ready.
module aes128_iter_decrypt
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         new_key,
    input  logic [127:0] cipher_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_out,
    output logic         busy
);

    state_t       fsm, fsm_nxt;
    logic [3:0]   cnt;
    logic [127:0] blk, rk, k10_reg, step_out, isb;
    logic         key_cached;
    logic         step_dir;
    logic [7:0]   step_rcon;

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);

    // KEXP walks forward with rcon[cnt]; ROUND walks back with rcon[cnt+1] to yield K_cnt.
    assign step_dir  = (fsm == ROUND);
    assign step_rcon = step_dir ? rcon(cnt + 4'd1) : rcon(cnt);

    aes128_key_step u_key_step (
        .rk_in  (rk),
        .rcon   (step_rcon),
        .dir    (step_dir),
        .rk_out (step_out)
    );

    assign isb = inv_sub_bytes(inv_shift_rows(blk));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nxt;
    end

    // Next-state selection.
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:  if (in_valid) fsm_nxt = (new_key || !key_cached) ? KEXP : ARK;
            KEXP:  if (cnt == 4'(NR)) fsm_nxt = ARK;
            ARK:   fsm_nxt = ROUND;
            ROUND: if (cnt == 4'd0) fsm_nxt = DONE;
            DONE:  if (out_ready) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // Datapath: block state, running round key, cached K10 and round counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk        <= '0;
            rk         <= '0;
            k10_reg    <= '0;
            key_cached <= 1'b0;
            cnt        <= '0;
            plain_out  <= '0;
        end else begin
            case (fsm)
                IDLE: if (in_valid) begin
                    blk <= cipher_in;
                    if (new_key || !key_cached) begin
                        rk  <= key_in;
                        cnt <= 4'd1;
                    end else begin
                        rk  <= k10_reg;
                    end
                end
                KEXP: begin
                    rk  <= step_out;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(NR)) begin
                        k10_reg    <= step_out;
                        key_cached <= 1'b1;
                    end
                end
                ARK: begin
                    blk <= blk ^ rk;
                    cnt <= 4'(NR - 1);
                end
                ROUND: begin
                    rk <= step_out;
                    if (cnt == 4'd0) begin
                        blk       <= isb ^ step_out;
                        plain_out <= isb ^ step_out;
                    end else begin
                        blk <= inv_mix_columns(isb ^ step_out);
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_iter_decrypt.sv
// Scoreboard bench for aes128_iter_decrypt using FIPS-197 vectors.
// Stimulus pushes expected plaintext/latency; a negedge monitor pops on each output handshake.
// Covers cached/new key, backpressure hold, forced expansion and mid-run reset abort.
module tb_aes128_iter_decrypt;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K10A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk, rst;
    logic         in_valid, in_ready, new_key, out_valid, out_ready, busy;
    logic [127:0] cipher_in, key_in, plain_out;

    aes128_iter_decrypt #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .new_key   (new_key),
        .cipher_in (cipher_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plain_out (plain_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pt;
        int           lat;
        time          t_acc;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Present one block at posedge+1, push its expectation at the accepting edge.
    task automatic issue(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt,
                         input logic nk, input int lat, input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            fail_now({tag, "_in_ready_timeout"});
            return;
        end
        in_valid  = 1'b1;
        new_key   = nk;
        cipher_in = ct;
        key_in    = key;
        @(posedge clk);
        e.pt = pt; e.lat = lat; e.t_acc = $time; e.tag = tag;
        sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() > 0) begin
            fail_now({tag, "_drain_timeout"});
            sb.delete();
        end
    endtask

    // Monitor: compares on first sight of out_valid, checks hold stability, pops on handshake.
    initial begin : monitor
        logic         seen, unstable;
        logic [127:0] first;
        int           held, lat;
        seen = 1'b0; unstable = 1'b0; held = 0; first = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1; first = plain_out; held = 0; unstable = 1'b0;
                    if (sb.size() == 0) begin
                        fail_now("unexpected_out_valid");
                    end else begin
                        lat = int'(($time - sb[0].t_acc + 5) / 10);
                        check({sb[0].tag, "_plaintext"}, plain_out, sb[0].pt);
                        check({sb[0].tag, "_latency"}, 128'(lat), 128'(sb[0].lat));
                    end
                end else begin
                    held++;
                    if (plain_out !== first) unstable = 1'b1;
                end
                if (out_ready) begin
                    if (held > 0) check("hold_plain_stable", 128'(unstable), 128'd0);
                    if (sb.size() > 0) void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        logic ir_seen;
        int   n;
        rst = 1'b1; in_valid = 1'b0; new_key = 1'b0; out_ready = 1'b1;
        cipher_in = '0; key_in = '0;

        @(posedge clk); #1;
        check("reset_in_ready",  128'(in_ready),  128'd1);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_busy",      128'(busy),      128'd0);
        check("reset_plain_out", plain_out,       128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fresh key expansion, then the cached path, then a key change.
        issue(KEY1, CT1, PT1, 1'b1, 22, "c1_newkey");
        drain("c1_newkey");
        check("c1_k10_reg", dut.k10_reg, K10A);
        issue(KEY1, CT1, PT1, 1'b0, 12, "c1_cached");
        drain("c1_cached");
        issue(KEY2, CT2, PT2, 1'b1, 22, "b_switch");
        drain("b_switch");
        check("b_k10_reg", dut.k10_reg, K10B);

        // Backpressure: hold the result 20 cycles while a stray input is offered.
        out_ready = 1'b0;
        issue(KEY2, CT2, PT2, 1'b0, 12, "bp");
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) fail_now("bp_out_valid_timeout");
        ir_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                in_valid = 1'b1; new_key = 1'b1; key_in = KEY1; cipher_in = CT1;
            end
            if (i == 10) in_valid = 1'b0;
            @(posedge clk); #1;
            if (in_ready) ir_seen = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_in_ready_low",  128'(ir_seen),   128'd0);
        check("bp_out_valid_held", 128'(out_valid), 128'd1);
        check("bp_plain_held",     plain_out,       PT2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  128'(in_ready),  128'd1);
        check("bp_release_busy",      128'(busy),      128'd0);
        check("bp_release_out_valid", 128'(out_valid), 128'd0);
        check("bp_k10_unchanged",     dut.k10_reg,     K10B);
        drain("bp");

        // Reset clears the cache: new_key=0 still expands.
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        issue(KEY1, CT1, PT1, 1'b0, 22, "first_use_forced");
        drain("first_use_forced");

        // Abort in ROUND at cnt=5; the partial block must never surface.
        issue(KEY1, CT1, PT1, 1'b0, 12, "abort");
        repeat (5) @(posedge clk);
        #2;
        check("abort_point_cnt", 128'(dut.cnt), 128'd5);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_in_ready",  128'(in_ready),  128'd1);
        check("abort_busy",      128'(busy),      128'd0);
        sb.delete();
        #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        issue(KEY1, CT1, PT1, 1'b0, 22, "after_abort");
        drain("after_abort");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes128_iter_decrypt.md
Name: aes128_iter_decrypt

Overview:
Iterative AES-128 inverse cipher. It takes one ciphertext block and a cipher key through a valid/ready handshake and returns the plaintext through a second valid/ready handshake. It is the receive-side counterpart to the unrolled encrypt datapath. One inverse round is computed per cycle, and round keys are generated on the fly: a forward expansion to K10, then reverse stepping K10 down to K0. The last K10 is cached, so back-to-back blocks under the same key skip re-expansion.

Parameters:
NR, 10, number of rounds (fixed for AES-128; any other value is illegal)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  ciphertext/key presented
in_ready  out  1  block can accept input
new_key  in  1  1 = expand key_in; 0 = reuse cached K10
cipher_in  in  128  ciphertext; byte 0 in [127:120]
key_in  in  128  cipher key K0; byte 0 in [127:120]
out_valid  out  1  plain_out holds a result
out_ready  in  1  consumer accepts result
plain_out  out  128  plaintext, same byte order
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=1), all values forced immediately:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - plain_out = 0, key_cached = 0, round counter = 0.
- FSM states: IDLE, KEXP, ARK, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - An accept happens when in_valid && in_ready.
  - On accept, latch cipher_in into the state register.
  - If new_key = 1 or key_cached = 0: load rk <= key_in, cnt = 1, go to KEXP.
  - Otherwise: load rk <= k10_reg, go to ARK.
- KEXP (10 cycles):
  - Each cycle: rk <= fwd_step(rk, rcon[cnt]), cnt++.
  - After cnt = 10: k10_reg <= result, key_cached <= 1, go to ARK.
- ARK (1 cycle): state ^= rk (rk = K10), cnt = 9, go to ROUND.
- ROUND (10 cycles):
  - Each cycle: rk <= inv_step(rk, rcon[cnt+1]), giving K_cnt.
  - For cnt 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ K_cnt).
  - For cnt = 0: state <= InvSubBytes(InvShiftRows(state)) ^ K0, then go to DONE.
- DONE:
  - out_valid = 1; plain_out holds the result and stays stable until out_ready.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE.
  - in_ready stays 0 during DONE; there is no overlap.
- Latency, from the accept edge to the first edge with out_valid = 1:
  - cached key: 12 cycles (ARK + 10 rounds + 1 register).
  - new key: 22 cycles.
- Key step functions (words w0..w3, w0 = [127:96]):
  - fwd_step: w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - inv_step: w3' = w3 ^ w2; w2' = w2 ^ w1; w1' = w1 ^ w0; w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36, placed in the top byte.
- in_valid while not in IDLE is ignored, and inputs are not sampled.
- new_key = 0 with key_cached = 0 is treated as new_key = 1.
- rst asserted mid-operation:
  - Aborts immediately and clears key_cached.
  - Any partial result is discarded, and out_valid is never raised for it.
- out_ready held high in DONE gives a single-cycle out_valid pulse; held low, the result is retained indefinitely.

Decomposition:
- Package aes_pkg holds:
  - SBOX and INV_SBOX tables and the RCON table.
  - The state enum (IDLE, KEXP, ARK, ROUND, DONE).
  - Functions sub_word, rot_word, inv_shift_rows, inv_sub_bytes, inv_mix_columns.
- One sub-module, aes128_key_step: combinational, with inputs rk_in, rcon, dir (0 = forward, 1 = inverse) and output rk_out.
- The existing inverse-round primitives are reused for the round datapath.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, new_key=1, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plain_out 00112233445566778899aabbccddeeff at 22 cycles; internal k10_reg = 13111d7fe3944a17f307a78b4d2b30c5.
- Same key cached: new_key=0, same ct -> same plaintext at 12 cycles; KEXP never entered.
- Key switch: key 2b7e151628aed2a6abf7158809cf4f3c, new_key=1, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734; k10_reg = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> plain_out stable, in_ready=0, a new in_valid ignored; then out_ready=1 -> return to IDLE next cycle.
- First use with new_key=0 after reset, C.1 vectors -> forced expansion, correct plaintext at 22 cycles.
- rst pulse during ROUND cnt=5 -> out_valid stays 0, in_ready=1, busy=0 immediately; next block with new_key=0 still expands (key_cached cleared).
